// File: rtl/block_output_pkg.sv
// block_output_pkg: shared NoC constants and direction encodings
package block_output_pkg;
  localparam int NOC_DATA_WIDTH = 8;
  localparam int NOC_FIFO_DEPTH = 4;
  localparam int NOC_N_PTR      = $clog2(NOC_FIFO_DEPTH);
  typedef enum logic [2:0] {DIR_LOCAL, DIR_N, DIR_E, DIR_S, DIR_W} dir_e;
  localparam int N_DIR = 5;
endpackage

// File: rtl/block_output_rr_arbiter.sv
// block_output_rr_arbiter: round-robin one-hot grant starting at i_rr_ptr
//   i_req[N_IN] requests, i_rr_ptr priority start, i_en gate
//   o_grant[N_IN] one-hot grant, o_idx winner index
module block_output_rr_arbiter #(
  parameter int N_IN = 4,
  parameter int IW   = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] i_req,
  input  logic [IW-1:0]   i_rr_ptr,
  input  logic            i_en,
  output logic [N_IN-1:0] o_grant,
  output logic [IW-1:0]   o_idx
);
  logic [2*N_IN-1:0] w_dbl;
  logic [N_IN-1:0]   w_rot;
  logic [IW-1:0]     w_off;
  logic [IW:0]       w_sum;
  logic              w_any;
  // rotate so that bit 0 is the requester at i_rr_ptr
  assign w_dbl = {i_req, i_req} >> i_rr_ptr;
  assign w_rot = w_dbl[N_IN-1:0];
  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (w_rot[i]) begin
        w_off = IW'(i);
        w_any = 1'b1;
      end
  end
  assign w_sum   = {1'b0, i_rr_ptr} + {1'b0, w_off};
  assign o_idx   = (w_sum >= (IW+1)'(N_IN)) ? IW'(w_sum - (IW+1)'(N_IN)) : w_sum[IW-1:0];
  assign o_grant = (i_en && w_any) ? (N_IN'(1) << o_idx) : '0;
endmodule

// File: rtl/block_output.sv
// block_output: NoC router output port, round-robin arbitration into a FIFO driving a val/ret link
//   clk, rst (async active-low); req/Data_in from input blocks, grant back to them
//   val/Data_out toward the neighbour, ret = neighbour not full; full = output FIFO full
//   BLOCK_OUTPUT_PKT_CNT_EN adds pkt_cnt[15:0], a saturating count of link transfers
module block_output
  import block_output_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int N_IN       = 4,
  parameter int FIFO_DEPTH = NOC_FIFO_DEPTH,
  parameter int N_PTR      = NOC_N_PTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            req,
  input  logic [N_IN*DATA_WIDTH-1:0] Data_in,
  output logic [N_IN-1:0]            grant,
  output logic                       val,
  input  logic                       ret,
  output logic [DATA_WIDTH-1:0]      Data_out,
  output logic                       full
`ifdef BLOCK_OUTPUT_PKT_CNT_EN
  ,output logic [15:0]               pkt_cnt
`endif
);
  localparam int IW = $clog2(N_IN);
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] w_slice [N_IN];
  logic [DATA_WIDTH-1:0] w_din, r_data_out;
  logic [N_PTR-1:0]      r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [N_PTR:0]        r_cnt, w_cnt_next;
  logic [IW-1:0]         r_rr_ptr, w_idx;
  logic                  w_push, w_pop;
  for (genvar i = 0; i < N_IN; i++) begin : g_slice
    assign w_slice[i] = Data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // no grant while full, even if a read frees a slot this cycle, so grant never depends on ret
  block_output_rr_arbiter #(.N_IN(N_IN)) u_arb (
    .i_req   (req),
    .i_rr_ptr(r_rr_ptr),
    .i_en    (rst && !full),
    .o_grant (grant),
    .o_idx   (w_idx)
  );
  assign full       = r_cnt == (N_PTR+1)'(FIFO_DEPTH);
  assign val        = r_cnt != '0;
  assign Data_out   = r_data_out;
  assign w_push     = |grant;
  assign w_pop      = val && ret;
  assign w_din      = w_slice[w_idx];
  assign w_rd_next  = r_rd_ptr + N_PTR'(w_pop);
  assign w_cnt_next = r_cnt + (N_PTR+1)'(w_push) - (N_PTR+1)'(w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= w_din;
  // the head register loads the incoming flit when it lands in an otherwise empty slot order
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_data_out <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + N_PTR'(w_push);
      r_rd_ptr <= w_rd_next;
      r_cnt    <= w_cnt_next;
      if (w_push) r_rr_ptr <= (w_idx == IW'(N_IN - 1)) ? '0 : w_idx + IW'(1);
      if (w_cnt_next != '0)
        r_data_out <= (w_push && w_rd_next == r_wr_ptr) ? w_din : r_mem[w_rd_next];
    end
`ifdef BLOCK_OUTPUT_PKT_CNT_EN
  logic [15:0] r_pkt_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_pkt_cnt <= '0;
    else if (w_pop && r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  assign pkt_cnt = r_pkt_cnt;
`endif
endmodule

// File: tb/tb_block_output.sv
// tb_block_output: directed scoreboard bench for block_output
module tb_block_output;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ret = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] din = '0;
  logic [3:0]  grant;
  logic        val, full;
  logic [7:0]  dout;
`ifdef BLOCK_OUTPUT_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  always #5 clk = ~clk;
  block_output dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .Data_in (din),
    .grant   (grant),
    .val     (val),
    .ret     (ret),
    .Data_out(dout),
    .full    (full)
`ifdef BLOCK_OUTPUT_PKT_CNT_EN
    ,.pkt_cnt(pkt_cnt)
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic neg;
    @(negedge clk);
  endtask
  always @(negedge clk)
    if (rst && val && ret) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_flit: got %0h, want none", dout);
      end else check("flit", {24'b0, dout}, {24'b0, exp_q.pop_front()});
    end
  initial begin
    logic [3:0] rr_exp [5];
    int k;
    int cyc;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    neg;
    neg;
    check("rst_grant", grant, 0);
    check("rst_val", val, 0);
    check("rst_dout", dout, 0);
    check("rst_full", full, 0);
    tick;
    rst = 1'b1;
    ret = 1'b1;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA0);
    for (int i = 0; i < 5; i++) begin
      neg;
      check("rr_grant", grant, rr_exp[i]);
      tick;
    end
    req = 4'b0000;
    neg;
    tick;
    neg;
    check("empty_val", val, 0);
    check("empty_hold", dout, 8'hA0);
    tick;
    ret = 1'b0;
    req = 4'b0100;
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hB3);
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 4; i++) begin
      din[23:16] = 8'hB0 + 8'(i);
      neg;
      check("bp_grant", grant, 4'b0100);
      tick;
    end
    neg;
    check("bp_full", full, 1);
    check("bp_grant_blocked", grant, 0);
    check("bp_hold", dout, 8'hB0);
    tick;
    neg;
    check("bp_grant_blocked2", grant, 0);
    tick;
    ret = 1'b1;
    req = 4'b0001;
    din[7:0] = 8'hC0;
    neg;
    check("full_rd_grant", grant, 0);
    check("full_rd_full", full, 1);
    tick;
    neg;
    check("after_rd_grant", grant, 4'b0001);
    check("after_rd_full", full, 0);
    tick;
    req = 4'b0000;
    for (int i = 0; i < 3; i++) tick;
    neg;
    check("drain_val", val, 0);
    tick;
    din = {8'h00, 8'h00, 8'hE1, 8'hE0};
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE1);
    req = 4'b0010;
    neg;
    check("sparse_grant0", grant, 4'b0010);
    tick;
    req = 4'b0011;
    neg;
    check("sparse_wrap", grant, 4'b0001);
    tick;
    neg;
    check("sparse_next", grant, 4'b0010);
    tick;
    req = 4'b0000;
    tick;
    neg;
    check("sparse_empty", val, 0);
    tick;
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h50 + 8'(i));
    req = 4'b0001;
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 200) begin
      din[7:0] = 8'h50 + 8'(k);
      ret = ~ret;
      neg;
      if (grant[0]) k++;
      tick;
      cyc++;
    end
    check("stream_budget", k, 10);
    req = 4'b0000;
    ret = 1'b1;
    for (int i = 0; i < 20 && val; i++) tick;
    check("stream_drained", val, 0);
`ifdef BLOCK_OUTPUT_PKT_CNT_EN
    check("pkt_cnt", pkt_cnt, 23);
    neg;
    force dut.r_pkt_cnt = 16'hFFFE;
    #1;
    release dut.r_pkt_cnt;
    tick;
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    req = 4'b0001;
    din[7:0] = 8'h61;
    tick;
    din[7:0] = 8'h62;
    tick;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick;
    check("pkt_cnt_sat", pkt_cnt, 16'hFFFF);
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/block_output.md
Name: block_output

Overview:
- Output port of a NoC router: arbitrates between input blocks requesting this direction and buffers the winning flit.
- Drives the flit to the neighbour router's input port using that port's val/ret handshake.
- This block is the transmitting end of that handshake; the neighbour's input block is the receiver.
- Instantiated once per router direction, between the switch request lines and the inter-router link.

Parameters:
- DATA_WIDTH, 8, flit width; must match the neighbour input block.
- N_IN, 4, number of requesting input blocks.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.
- N_PTR, 2, log2(FIFO_DEPTH); FIFO pointer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_IN  bit i high: input block i holds a head flit routed to this port.
- Data_in  input  N_IN*DATA_WIDTH  flattened flits; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  output  N_IN  one-hot grant back to input blocks; input i pops its buffer on grant[i].
- val  output  1  flit valid toward the neighbour router.
- ret  input  1  neighbour ready; high means the neighbour buffer is not full.
- Data_out  output  DATA_WIDTH  flit toward the neighbour.
- full  output  1  output FIFO full.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO write/read pointers and count cleared.
  - Round-robin pointer cleared to 0.
  - Outputs: grant = 0, val = 0, Data_out = 0, full = 0.
- Arbitration (combinational from req, rr_ptr, full):
  - If full = 1 or req = 0, then grant = 0.
  - Otherwise grant the first requester at or above rr_ptr, wrapping modulo N_IN.
- Write: when grant[k] = 1, slice k of Data_in is written into the FIFO on that clk edge.
  - On the same edge, rr_ptr <= k+1 modulo N_IN.
  - rr_ptr is unchanged when there is no grant.
- Output handshake:
  - val = !empty; Data_out = FIFO head, registered and held stable while val=1 and ret=0.
  - Transfer occurs on a clk edge where val=1 and ret=1; the read pointer then advances.
  - val must not depend combinationally on ret.
- Latency: a flit granted in cycle t appears on Data_out with val=1 in cycle t+1 if the FIFO was empty.
- Simultaneous write and read: allowed when not full; count is unchanged and both pointers advance.
- Full boundary: full blocks the grant even if a read happens in the same cycle. No bypass; this keeps the grant path independent of ret.
- Empty boundary: val=0 and Data_out holds the last value; ret is ignored.
- Wrap-around: pointers wrap naturally at FIFO_DEPTH; count is N_PTR+1 bits.
- Reset mid-transfer: buffered flits are discarded. The neighbour sees val fall asynchronously; the system resets both routers together.

Optional Feature:
- Macro: BLOCK_OUTPUT_PKT_CNT_EN.
- Defined:
  - Extra output pkt_cnt[15:0] counts completed link transfers (val && ret edges).
  - The counter saturates at 16'hFFFF and clears on reset.
- Undefined: no port, no counter logic; the interface is exactly as listed above.

Decomposition:
- Shared NoC package holds:
  - DATA_WIDTH default and N_PTR derivation constant.
  - Direction encodings (local/N/E/S/W) used to size N_IN per router.
- One natural sub-module: rr_arbiter (req, rr_ptr, enable -> one-hot grant, winner index).
- The FIFO stays inline; it differs from the input-side buffer by the registered head and no-bypass rule.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 -> grant=0, val=0, Data_out=0, full=0; release, then next cycle grant=4'b0001.
- Round robin: req=4'b1111 continuous, ret=1, Data_in slices 8'hA0..8'hA3 -> grant sequence 0001,0010,0100,1000,0001; Data_out sequence A0,A1,A2,A3 from cycle t+1.
- Backpressure: ret=0, req=4'b0100 with 4 distinct flits -> full=1 after 4 grants, grant=0 thereafter; Data_out holds first flit; raise ret -> flits drain in order with one per cycle.
- Full with simultaneous read: FIFO full, ret=1, req=4'b0001 -> no grant that cycle; grant=0001 the next cycle once count=3.
- Sparse request: rr_ptr=2, req=4'b0011 -> grant=0001 (wrap), then rr_ptr=1, and next grant=0010.
- BLOCK_OUTPUT_PKT_CNT_EN: 10 transfers with ret toggling -> pkt_cnt=10; force near-saturation -> pkt_cnt holds at 16'hFFFF.
